// File: rtl/mem_mport_pkg.sv
// Shared definitions for the multi-port memory: controller state and helpers.
package mem_mport_pkg;

    // INIT clears the array one word per cycle; RUN serves port requests.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of a pointer that can name any of n ports (at least one bit).
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_mport_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found starting at ptr.
module rr_arbiter
    import mem_mport_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]            req,
    input  logic [ptrWidth(N)-1:0]  ptr,
    output logic [N-1:0]            gnt
);

    localparam int PW = ptrWidth(N);

    logic [PW-1:0] idx;
    logic          found;

    // Walk the ports in order ptr, ptr+1, ... (wrapping) and grant the first one requesting.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_mport.sv
// Multi-port word memory with byte strobes, round-robin access and power-up clear.
module mem_mport
    import mem_mport_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_PORTS  = 2
) (
    input  logic                            clk,
    input  logic                            res,
    input  logic [NUM_PORTS-1:0]            valid,
    output logic [NUM_PORTS-1:0]            ready,
    input  logic [NUM_PORTS-1:0]            wr_rd,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_PORTS*WIDTH-1:0]      wdata,
    input  logic [NUM_PORTS*WIDTH/8-1:0]    wstrb,
    output logic [NUM_PORTS-1:0]            rvalid,
    output logic [NUM_PORTS*WIDTH-1:0]      rdata,
    output logic [NUM_PORTS-1:0]            err,
    output logic                            busy
);

    localparam int BYTES = WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = ptrWidth(NUM_PORTS);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           initIdx_q, initIdx_d;
    logic [PTR_W-1:0]           rrPtr_q, rrPtr_d;
    logic [NUM_PORTS-1:0]       rvalid_q, rvalid_d;
    logic [NUM_PORTS*WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_PORTS-1:0]       err_q, err_d;

    logic [NUM_PORTS-1:0]  gnt;
    logic [NUM_PORTS-1:0]  accept;
    logic                  selWr;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [WIDTH-1:0]      selWdata;
    logic [BYTES-1:0]      selStrb;
    logic                  selInRange;
    logic [IDX_W-1:0]      selIdx;
    logic [WIDTH-1:0]      readWord;

    logic                  memWe;
    logic [IDX_W-1:0]      memIdx;
    logic [WIDTH-1:0]      memWdata;
    logic [BYTES-1:0]      memBe;

    logic [WIDTH-1:0] mem [DEPTH];

    rr_arbiter #(
        .N   (NUM_PORTS)
    ) uArbiter (
        .req (valid),
        .ptr (rrPtr_q),
        .gnt (gnt)
    );

    // State register: controller state, clear index, arbitration pointer and response registers.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= INIT;
            initIdx_q <= '0;
            rrPtr_q   <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            initIdx_q <= initIdx_d;
            rrPtr_q   <= rrPtr_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Next state: step through the clear, then move the pointer past whichever port was served.
    always_comb begin
        state_d   = state_q;
        initIdx_d = initIdx_q;
        rrPtr_d   = rrPtr_q;
        if (state_q == INIT) begin
            initIdx_d = initIdx_q + IDX_W'(1);
            if (initIdx_q == LAST_IDX) begin
                state_d   = RUN;
                initIdx_d = '0;
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (accept[p]) begin
                rrPtr_d = PTR_W'((p + 1) % NUM_PORTS);
            end
        end
    end

    // Outputs of the controller: busy while clearing, grants only in RUN and never during reset.
    always_comb begin
        busy   = (state_q == INIT);
        ready  = ((state_q == RUN) && !res) ? gnt : '0;
        accept = valid & ready;
    end

    // Pick the fields of the single accepted request (grants are one-hot, so an OR-mux is enough).
    always_comb begin
        selWr    = 1'b0;
        selAddr  = '0;
        selWdata = '0;
        selStrb  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (accept[p]) begin
                selWr    = wr_rd[p];
                selAddr  = addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                selWdata = wdata[p*WIDTH +: WIDTH];
                selStrb  = wstrb[p*BYTES +: BYTES];
            end
        end
    end

    assign selInRange = ({1'b0, selAddr} < DEPTH_LIM);
    assign selIdx     = selAddr[IDX_W-1:0];
    assign readWord   = mem[selIdx];

    // Single write port shared between the clear sequence and accepted in-range writes.
    always_comb begin
        memWe    = 1'b0;
        memIdx   = selIdx;
        memWdata = selWdata;
        memBe    = selStrb;
        if (state_q == INIT) begin
            memWe    = !res;
            memIdx   = initIdx_q;
            memWdata = '0;
            memBe    = '1;
        end else if (|accept) begin
            memWe = selWr && selInRange;
        end
    end

    // Byte-enabled array write; no reset because the clear sequence initialises the contents.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int b = 0; b < BYTES; b++) begin
                if (memBe[b]) begin
                    mem[memIdx][b*8 +: 8] <= memWdata[b*8 +: 8];
                end
            end
        end
    end

    // Response for the served port: read data or zero, error on out-of-range; others hold.
    always_comb begin
        rvalid_d = accept;
        rdata_d  = rdata_q;
        err_d    = err_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (accept[p]) begin
                err_d[p]                   = !selInRange;
                rdata_d[p*WIDTH +: WIDTH]  = (selInRange && !selWr) ? readWord : '0;
            end
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign err    = err_q;

endmodule

// File: tb/tb_mem_mport.sv
// Self-checking bench for mem_mport with a word-array reference model.
module tb_mem_mport;

    logic        clk;
    logic        res;
    logic [1:0]  valid;
    logic [1:0]  ready;
    logic [1:0]  wr_rd;
    logic [9:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [1:0]  rvalid;
    logic [63:0] rdata;
    logic [1:0]  err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Reference model: memory contents, arbitration pointer and expected response registers.
    logic [31:0] mMem [16];
    int          mPtr;
    logic [1:0]  expRvalid;
    logic [1:0]  expErr;
    logic [31:0] expRd [2];

    mem_mport #(
        .WIDTH      (32),
        .DEPTH      (16),
        .ADDR_WIDTH (5),
        .NUM_PORTS  (2)
    ) dut (
        .clk    (clk),
        .res    (res),
        .valid  (valid),
        .ready  (ready),
        .wr_rd  (wr_rd),
        .addr   (addr),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .rvalid (rvalid),
        .rdata  (rdata),
        .err    (err),
        .busy   (busy)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-robin rule: first requesting port found starting from the pointer.
    function automatic logic [1:0] modelGrant(input logic [1:0] v, input int ptr);
        for (int k = 0; k < 2; k++) begin
            int p;
            p = (ptr + k) % 2;
            if (v[p]) return 2'(1 << p);
        end
        return 2'b00;
    endfunction

    // Compare registered outputs against the model after a clock edge.
    task automatic checkOutput(input string tag);
        checks++;
        assert (rvalid === expRvalid) else begin
            failures++;
            $error("[TB] FAIL %s rvalid got=%b exp=%b", tag, rvalid, expRvalid);
        end
        checks++;
        assert (err === expErr) else begin
            failures++;
            $error("[TB] FAIL %s err got=%b exp=%b", tag, err, expErr);
        end
        for (int p = 0; p < 2; p++) begin
            checks++;
            assert (rdata[p*32 +: 32] === expRd[p]) else begin
                failures++;
                $error("[TB] FAIL %s rdata[%0d] got=%h exp=%h", tag, p, rdata[p*32 +: 32], expRd[p]);
            end
        end
        checks++;
        assert (busy === 1'b0) else begin
            failures++;
            $error("[TB] FAIL %s busy got=%b exp=0", tag, busy);
        end
    endtask

    // One RUN cycle: drive requests, check the grant, advance the model, check the response.
    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] w,
                                 input logic [4:0] a0, input logic [4:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [3:0] s0, input logic [3:0] s1,
                                 input string tag, output logic [1:0] gotReady);
        logic [1:0] g;
        logic [4:0] a;
        logic [31:0] d;
        logic [3:0] s;
        valid = v;
        wr_rd = w;
        addr  = {a1, a0};
        wdata = {d1, d0};
        wstrb = {s1, s0};
        #1;
        g        = modelGrant(v, mPtr);
        gotReady = ready;
        checks++;
        assert (ready === g) else begin
            failures++;
            $error("[TB] FAIL %s ready got=%b exp=%b", tag, ready, g);
        end
        expRvalid = g;
        for (int p = 0; p < 2; p++) begin
            if (g[p]) begin
                a = (p == 0) ? a0 : a1;
                d = (p == 0) ? d0 : d1;
                s = (p == 0) ? s0 : s1;
                if (a >= 5'd16) begin
                    expErr[p] = 1'b1;
                    expRd[p]  = 32'h0;
                end else if (w[p]) begin
                    expErr[p] = 1'b0;
                    expRd[p]  = 32'h0;
                    for (int b = 0; b < 4; b++) begin
                        if (s[b]) mMem[a[3:0]][b*8 +: 8] = d[b*8 +: 8];
                    end
                end else begin
                    expErr[p] = 1'b0;
                    expRd[p]  = mMem[a[3:0]];
                end
                mPtr = (p + 1) % 2;
            end
        end
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Hold reset for one edge (optionally with a request offered) and check the cleared outputs.
    task automatic doReset(input logic [1:0] v, input string tag);
        res   = 1'b1;
        valid = v;
        wr_rd = 2'b00;
        addr  = {5'd7, 5'd7};
        #1;
        checks++;
        assert (ready === 2'b00) else begin
            failures++;
            $error("[TB] FAIL %s ready-in-reset got=%b exp=00", tag, ready);
        end
        @(posedge clk);
        #1;
        checks++;
        assert (rvalid === 2'b00) else begin
            failures++;
            $error("[TB] FAIL %s rvalid got=%b exp=00", tag, rvalid);
        end
        checks++;
        assert (rdata === 64'h0) else begin
            failures++;
            $error("[TB] FAIL %s rdata got=%h exp=0", tag, rdata);
        end
        checks++;
        assert (err === 2'b00) else begin
            failures++;
            $error("[TB] FAIL %s err got=%b exp=00", tag, err);
        end
        checks++;
        assert (busy === 1'b1) else begin
            failures++;
            $error("[TB] FAIL %s busy got=%b exp=1", tag, busy);
        end
        res       = 1'b0;
        valid     = 2'b00;
        mPtr      = 0;
        expRvalid = 2'b00;
        expErr    = 2'b00;
        expRd[0]  = 32'h0;
        expRd[1]  = 32'h0;
    endtask

    // Count busy cycles after reset release while both ports request; bounded wait.
    task automatic waitInit(input string tag);
        int   cnt;
        logic sawReady;
        cnt      = 0;
        sawReady = 1'b0;
        valid    = 2'b11;
        wr_rd    = 2'b00;
        addr     = {5'd0, 5'd0};
        #1;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b1) break;
            cnt++;
            if (ready !== 2'b00) sawReady = 1'b1;
            @(posedge clk);
            #1;
        end
        valid = 2'b00;
        checks++;
        assert (cnt === 16) else begin
            failures++;
            $error("[TB] FAIL %s busy-cycles got=%0d exp=16", tag, cnt);
        end
        checks++;
        assert (sawReady === 1'b0) else begin
            failures++;
            $error("[TB] FAIL %s ready-during-init got=%b exp=0", tag, sawReady);
        end
        for (int i = 0; i < 16; i++) mMem[i] = 32'h0;
    endtask

    logic [1:0]  g;
    logic        pv [2];
    logic        pw [2];
    logic [4:0]  pa [2];
    logic [31:0] pd [2];
    logic [3:0]  ps [2];
    int          waitCnt [2];
    int          maxWait;

    initial begin
        res   = 1'b0;
        valid = 2'b00;
        wr_rd = 2'b00;
        addr  = '0;
        wdata = '0;
        wstrb = '0;
        mPtr  = 0;

        // Power-up clear.
        doReset(2'b00, "reset");
        waitInit("init");
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) applyStimulus(2'b01, 2'b00, 5'(i), 5'd0, 32'h0, 32'h0, 4'h0, 4'h0, "init-read", g);
            else            applyStimulus(2'b10, 2'b00, 5'd0, 5'(i), 32'h0, 32'h0, 4'h0, 4'h0, "init-read", g);
        end

        // Byte strobes.
        applyStimulus(2'b01, 2'b01, 5'd3, 5'd0, 32'hAABBCCDD, 32'h0, 4'hF, 4'h0, "strb-wr1", g);
        applyStimulus(2'b01, 2'b01, 5'd3, 5'd0, 32'h11223344, 32'h0, 4'h5, 4'h0, "strb-wr2", g);
        applyStimulus(2'b01, 2'b00, 5'd3, 5'd0, 32'h0, 32'h0, 4'h0, 4'h0, "strb-rd", g);
        checks++;
        assert (rdata[31:0] === 32'hAA22CC44) else begin
            failures++;
            $error("[TB] FAIL strb-value got=%h exp=aa22cc44", rdata[31:0]);
        end

        // Contention: both ports request continuously.
        waitCnt[0] = 0;
        waitCnt[1] = 0;
        maxWait    = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(2'b11, 2'b00, 5'd3, 5'd5, 32'h0, 32'h0, 4'h0, 4'h0, "contend", g);
            for (int p = 0; p < 2; p++) begin
                waitCnt[p] = g[p] ? 0 : waitCnt[p] + 1;
                if (waitCnt[p] > maxWait) maxWait = waitCnt[p];
            end
        end
        checks++;
        assert (maxWait <= 1) else begin
            failures++;
            $error("[TB] FAIL contend-wait got=%0d exp<=1", maxWait);
        end

        // Out-of-range write, then confirm memory untouched.
        applyStimulus(2'b10, 2'b10, 5'd0, 5'd20, 32'h0, 32'hDEADBEEF, 4'h0, 4'hF, "oor-wr", g);
        checks++;
        assert (err[1] === 1'b1) else begin
            failures++;
            $error("[TB] FAIL oor-err got=%b exp=1", err[1]);
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(2'b01, 2'b00, 5'(i), 5'd0, 32'h0, 32'h0, 4'h0, 4'h0, "oor-reread", g);
        end

        // Back-to-back write then read, plus an all-strobes-off write.
        applyStimulus(2'b01, 2'b01, 5'd7, 5'd0, 32'h5, 32'h0, 4'hF, 4'h0, "b2b-wr", g);
        applyStimulus(2'b01, 2'b00, 5'd7, 5'd0, 32'h0, 32'h0, 4'h0, 4'h0, "b2b-rd", g);
        checks++;
        assert (rdata[31:0] === 32'h5) else begin
            failures++;
            $error("[TB] FAIL b2b-value got=%h exp=00000005", rdata[31:0]);
        end
        applyStimulus(2'b10, 2'b10, 5'd0, 5'd7, 32'h0, 32'hFFFFFFFF, 4'h0, 4'h0, "strb0-wr", g);
        applyStimulus(2'b10, 2'b00, 5'd0, 5'd7, 32'h0, 32'h0, 4'h0, 4'h0, "strb0-rd", g);

        // Random traffic; unserved requests are held until granted.
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        for (int c = 0; c < 120; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && ($urandom_range(0, 3) != 0)) begin
                    pv[p] = 1'b1;
                    pw[p] = 1'($urandom_range(0, 1));
                    pa[p] = 5'($urandom_range(0, 19));
                    pd[p] = $urandom;
                    ps[p] = 4'($urandom_range(0, 15));
                end else if (!pv[p]) begin
                    pw[p] = 1'b0;
                    pa[p] = 5'd0;
                    pd[p] = 32'h0;
                    ps[p] = 4'h0;
                end
            end
            applyStimulus({pv[1], pv[0]}, {pw[1], pw[0]}, pa[0], pa[1], pd[0], pd[1], ps[0], ps[1], "random", g);
            for (int p = 0; p < 2; p++) begin
                if (g[p]) pv[p] = 1'b0;
            end
        end

        // Reset the cycle after a read accept, then reset with a request offered.
        applyStimulus(2'b01, 2'b01, 5'd9, 5'd0, 32'h12345678, 32'h0, 4'hF, 4'h0, "mid-wr", g);
        applyStimulus(2'b01, 2'b00, 5'd9, 5'd0, 32'h0, 32'h0, 4'h0, 4'h0, "mid-rd", g);
        doReset(2'b01, "mid-reset");
        waitInit("reinit");
        applyStimulus(2'b01, 2'b00, 5'd9, 5'd0, 32'h0, 32'h0, 4'h0, 4'h0, "reinit-rd", g);
        checks++;
        assert (rdata[31:0] === 32'h0) else begin
            failures++;
            $error("[TB] FAIL reinit-value got=%h exp=0", rdata[31:0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
